fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//   Round-robin write-port arbiter that shares one 8-deep x 8-bit synchronous FIFO among N producers.
//   Grants one requester at a time for a bounded burst, drives the FIFO write strobe/data, and stalls on FIFO full.
//   Sits directly in front of the FIFO write port; the FIFO read side is untouched.
// PARAMETERS
//   N_REQ      4   number of requesters (2..8)
//   DW         8   data width per requester, equal to the FIFO data width
//   MAX_BURST  4   max accepted beats per grant before forced re-arbitration (1..15)
// PORTS
//   clk        in   1          clock, all state updates on posedge
//   rst        in   1          synchronous, active-high reset
//   req        in   N_REQ      per-requester valid; held high while data is pending
//   req_data   in   N_REQ*DW   packed data; requester i occupies [i*DW +: DW]
//   ack        out  N_REQ      per-requester accept; a beat transfers when req[i] & ack[i]
//   fifo_full  in   1          FIFO full flag (count == 8)
//   fifo_wr    out  1          FIFO write strobe
//   fifo_din   out  DW         FIFO write data
//   gnt_id     out  3          index of the current grant owner (valid when busy)
//   busy       out  1          high in state BURST
// BEHAVIOUR
//   - Reset: state=IDLE, gnt_id=0, busy=0, beat_cnt=0, last_owner=N_REQ-1 (requester 0 has first priority).
//     ack, fifo_wr and fifo_din are combinational: ack=0 and fifo_wr=0 in IDLE. fifo_din is don't-care when fifo_wr=0.
//   - FSM states:
//     IDLE:  if |req, pick the first asserted req scanning last_owner+1, +2, ... (mod N_REQ).
//            Register gnt_id, clear beat_cnt, go to BURST. No beat is accepted in IDLE.
//            This gives a 1-cycle arbitration bubble per grant.
//     BURST: ack[gnt_id] = req[gnt_id] & ~fifo_full; all other ack bits are 0.
//            fifo_wr = ack[gnt_id]; fifo_din = req_data slice for gnt_id.
//            On each write, beat_cnt increments.
//   - BURST exit to IDLE (last_owner <= gnt_id) when either:
//     (a) a write occurs with beat_cnt == MAX_BURST-1, or
//     (b) req[gnt_id] == 0.
//     Otherwise the FSM stays in BURST.
//   - fifo_full in BURST: the owner stalls (ack=0) and keeps its grant; beat_cnt is held. No timeout.
//   - The owner dropping req while full still releases the grant via (b).
//   - Single requester: it is re-granted after the 1-cycle IDLE bubble; maximum throughput is MAX_BURST/(MAX_BURST+1).
//   - beat_cnt is 4 bits, never exceeds MAX_BURST-1, and is cleared on grant.
//   - last_owner wraps modulo N_REQ. Requests arriving while another owner is in BURST wait; no preemption.
//   - Reset mid-burst: the FSM returns to IDLE next edge and ack/fifo_wr drop immediately. A partial burst is not resumed.
//   - The arbiter never writes when fifo_full=1, including when the FIFO is being read that same cycle.
// STRUCTURE
//   - fifo_arb_pkg: state enum {IDLE, BURST}; localparam GNT_W = 3, BCNT_W = 4.
//   - Sub-module rr_pick: purely combinational.
//     Inputs req[N_REQ] and last_owner; outputs found and idx (rotate, priority-encode, un-rotate).
//   - Top level: FSM, beat counter, owner register, and the ack/fifo_wr/fifo_din muxing.
// TESTING
//   1. Reset with req=4'b1111 held.
//      -> First grant goes to 0 (cycle 2). Req0 gets 4 beats, then a bubble.
//      -> Grants then follow 1,2,3,0; fifo_wr is never high in IDLE.
//   2. req=4'b0100 only, data 0x10..0x1B, fifo never full.
//      -> 12 writes in order, gnt_id=2 throughout, one idle cycle after every 4th beat.
//   3. Owner 1 in BURST, fifo_full rises after 2 beats for 5 cycles.
//      -> ack=0 and fifo_wr=0 for 5 cycles, gnt_id stays 1.
//      -> Beats 3 and 4 complete after full falls, then re-arbitration.
//   4. Owner 3 drops req after 1 beat while req0 is pending.
//      -> IDLE next cycle, grant to 0 (wrap from 3), beat_cnt cleared.
//   5. rst pulsed mid-burst (owner 2, beat 2).
//      -> ack=0 and fifo_wr=0 that cycle, state=IDLE, last_owner=N_REQ-1, next grant to 0.
//   6. Random req/full stress against a scoreboard model.
//      -> No FIFO write while full, per-requester data order preserved, no requester waits more than N_REQ grants.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and widths for the FIFO write-port arbiter.
`timescale 1ns/1ps
package fifo_arb_pkg;

    // IDLE arbitrates, BURST owns the FIFO write port.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Owner index width (covers up to 8 requesters).
    localparam int GNT_W  = 3;
    // Beat counter width (covers a burst limit of up to 15).
    localparam int BCNT_W = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: the first asserted request after last_owner, wrapping.
`timescale 1ns/1ps
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [GNT_W-1:0] last_owner,
    output logic             found,
    output logic [GNT_W-1:0] idx
);

    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    // cand[k] is the k-th requester in scan order; rot[k] says whether it is asking.
    logic [GNT_W-1:0] cand [N_REQ];
    logic [N_REQ-1:0] rot;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign cand[gi] = GNT_W'((int'(last_owner) + gi + 1) % N_REQ);
            assign rot[gi]  = |(req & (ONE_HOT0 << cand[gi]));
        end
    endgenerate

    // Priority-encode the rotated vector; scanning downwards lets the lowest hit win.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers in bounded bursts.
`timescale 1ns/1ps
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    ack,
    input  logic                fifo_full,
    output logic                fifo_wr,
    output logic [DW-1:0]       fifo_din,
    output logic [GNT_W-1:0]    gnt_id,
    output logic                busy
);

    arb_state_t        state_reg, state_next;
    logic [GNT_W-1:0]  gnt_id_reg, gnt_id_next;
    logic [GNT_W-1:0]  last_owner_reg, last_owner_next;
    logic [BCNT_W-1:0] beat_cnt_reg, beat_cnt_next;

    logic              pick_found;
    logic [GNT_W-1:0]  pick_idx;

    logic [DW-1:0]     data_arr [N_REQ];
    logic              owner_req;
    logic [DW-1:0]     owner_data;
    logic [N_REQ-1:0]  owner_mask;
    logic              wr_en;
    logic              last_beat;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign data_arr[gi] = req_data[gi*DW +: DW];
        end
    endgenerate

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req        (req),
        .last_owner (last_owner_reg),
        .found      (pick_found),
        .idx        (pick_idx)
    );

    // Select the current owner's request, data and ack bit.
    always_comb begin
        owner_req  = 1'b0;
        owner_data = '0;
        owner_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_id_reg == GNT_W'(i)) begin
                owner_req     = req[i];
                owner_data    = data_arr[i];
                owner_mask[i] = 1'b1;
            end
        end
    end

    // Reset gates the strobe so a reset mid-burst drops the write in the same cycle.
    assign wr_en     = (state_reg == BURST) && owner_req && !fifo_full && !rst;
    assign last_beat = (beat_cnt_reg == BCNT_W'(MAX_BURST - 1));
    assign ack       = wr_en ? owner_mask : '0;
    assign fifo_wr   = wr_en;
    assign fifo_din  = owner_data;
    assign gnt_id    = gnt_id_reg;
    assign busy      = (state_reg == BURST);

    // Next-state logic: grant from IDLE, count beats and release in BURST.
    always_comb begin
        state_next      = state_reg;
        gnt_id_next     = gnt_id_reg;
        last_owner_next = last_owner_reg;
        beat_cnt_next   = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    state_next    = BURST;
                    gnt_id_next   = pick_idx;
                    beat_cnt_next = '0;
                end
            end
            BURST: begin
                if (wr_en) begin
                    beat_cnt_next = beat_cnt_reg + BCNT_W'(1);
                end
                if ((wr_en && last_beat) || !owner_req) begin
                    state_next      = IDLE;
                    last_owner_next = gnt_id_reg;
                    beat_cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State registers; requester 0 gets first priority out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            gnt_id_reg     <= '0;
            last_owner_reg <= GNT_W'(N_REQ - 1);
            beat_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            gnt_id_reg     <= gnt_id_next;
            last_owner_reg <= last_owner_next;
            beat_cnt_reg   <= beat_cnt_next;
        end
    end

endmodule
